// File: rtl/ysyx_040750_defs.sv
// Shared definitions for the write-back unit: datapath width, load formats,
// state encoding and the latched instruction context.
package ysyx_040750_defs;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OFF_W = 3;

    // funct3 of a load; 3'b111 is handled as a full doubleword
    typedef enum logic [FMT_W-1:0] {
        FMT_LB  = 3'b000,
        FMT_LH  = 3'b001,
        FMT_LW  = 3'b010,
        FMT_LD  = 3'b011,
        FMT_LBU = 3'b100,
        FMT_LHU = 3'b101,
        FMT_LWU = 3'b110,
        FMT_LDX = 3'b111
    } load_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_WRITE     = 2'd2
    } wbu_state_t;

    // Per-instruction context captured on accept
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             rd_wen;
        logic [XLEN-1:0]  pc;
    } wb_ctx_t;

endpackage

// File: rtl/ysyx_040750_load_ext.sv
// Load data extraction: shift the doubleword down by the byte offset, then
// truncate and sign/zero-extend according to the load format.
module ysyx_040750_load_ext
    import ysyx_040750_defs::*;
(
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [FMT_W-1:0] fmt,
    output logic [XLEN-1:0]  data_c
);

    logic [XLEN-1:0] shifted;

    // Byte-offset shift with zero fill; misaligned accesses just see fewer bytes
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data_c  = shifted;
        case (load_fmt_t'(fmt))
            FMT_LB:  data_c = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            FMT_LH:  data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            FMT_LW:  data_c = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            FMT_LBU: data_c = {{(XLEN-8){1'b0}},         shifted[7:0]};
            FMT_LHU: data_c = {{(XLEN-16){1'b0}},        shifted[15:0]};
            FMT_LWU: data_c = {{(XLEN-32){1'b0}},        shifted[31:0]};
            FMT_LD,
            FMT_LDX: data_c = shifted;
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_040750_wbu.sv
// Write-back unit: accepts retiring instructions, waits for load data,
// and drives the single GPR write port plus forwarding and commit signals.
module ysyx_040750_wbu #(
    parameter int unsigned XLEN = ysyx_040750_defs::XLEN
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [4:0]      I_rd_addr,
    input  logic            I_rd_wen,
    input  logic [XLEN-1:0] I_result,
    input  logic            I_is_load,
    input  logic [2:0]      I_load_fmt,
    input  logic [XLEN-1:0] I_pc,
    input  logic            I_mem_rvalid,
    input  logic [XLEN-1:0] I_mem_rdata,
    output logic            O_wen,
    output logic [4:0]      O_rd_addr,
    output logic [XLEN-1:0] O_wr_data,
    output logic            O_fwd_valid,
    output logic [4:0]      O_fwd_rd,
    output logic [XLEN-1:0] O_fwd_data,
    output logic            O_load_pending,
    output logic [4:0]      O_load_rd,
    output logic            O_commit,
    output logic [XLEN-1:0] O_commit_pc
);

    import ysyx_040750_defs::*;

    wbu_state_t       state_q;
    wbu_state_t       state_d;
    wb_ctx_t          ctx_q;
    logic [XLEN-1:0]  data_q;
    logic [FMT_W-1:0] fmt_q;
    logic [OFF_W-1:0] off_q;
    logic [XLEN-1:0]  ext_data;
    logic             accept;
    logic             load_done;

    assign accept    = I_valid & O_ready;
    assign load_done = (state_q == ST_WAIT_LOAD) & I_mem_rvalid;

    ysyx_040750_load_ext u_load_ext (
        .rdata  (I_mem_rdata),
        .offset (off_q),
        .fmt    (fmt_q),
        .data_c (ext_data)
    );

    // State register
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a WRITE cycle can accept the following instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = I_is_load ? ST_WAIT_LOAD : ST_WRITE;
            end
            ST_WAIT_LOAD: begin
                if (I_mem_rvalid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (accept) state_d = I_is_load ? ST_WAIT_LOAD : ST_WRITE;
                else        state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and held registers only
    always_comb begin
        O_ready        = 1'b1;
        O_wen          = 1'b0;
        O_fwd_valid    = 1'b0;
        O_commit       = 1'b0;
        O_load_pending = 1'b0;
        O_rd_addr      = ctx_q.rd;
        O_wr_data      = data_q;
        O_fwd_rd       = ctx_q.rd;
        O_fwd_data     = data_q;
        O_commit_pc    = ctx_q.pc;
        O_load_rd      = ctx_q.rd;
        if (state_q == ST_WAIT_LOAD) begin
            O_ready        = 1'b0;
            O_load_pending = 1'b1;
        end
        if (state_q == ST_WRITE) begin
            O_wen       = ctx_q.rd_wen & (ctx_q.rd != '0);
            O_fwd_valid = ctx_q.rd_wen & (ctx_q.rd != '0);
            O_commit    = 1'b1;
        end
    end

    // Context and data capture: on accept, and when load data returns
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            ctx_q  <= '0;
            data_q <= '0;
            fmt_q  <= '0;
            off_q  <= '0;
        end else if (accept) begin
            ctx_q.rd     <= I_rd_addr;
            ctx_q.rd_wen <= I_rd_wen;
            ctx_q.pc     <= I_pc;
            if (I_is_load) begin
                fmt_q <= I_load_fmt;
                off_q <= I_result[OFF_W-1:0];
            end else begin
                data_q <= I_result;
            end
        end else if (load_done) begin
            data_q <= ext_data;
        end
    end

endmodule

// File: tb/tb_ysyx_040750_wbu.sv
// Self-checking bench for the write-back unit: directed scenarios followed by
// randomized instruction streams checked against a byte-level load model.
module tb_ysyx_040750_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [63:0] result;
    logic        is_load;
    logic [2:0]  load_fmt;
    logic [63:0] pc;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wen;
    logic [4:0]  wr_rd;
    logic [63:0] wr_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        load_pending;
    logic [4:0]  load_rd;
    logic        commit;
    logic [63:0] commit_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_040750_wbu #(.XLEN(64)) dut (
        .I_sys_clk      (clk),
        .I_rst          (rst),
        .I_valid        (valid),
        .O_ready        (ready),
        .I_rd_addr      (rd_addr),
        .I_rd_wen       (rd_wen),
        .I_result       (result),
        .I_is_load      (is_load),
        .I_load_fmt     (load_fmt),
        .I_pc           (pc),
        .I_mem_rvalid   (mem_rvalid),
        .I_mem_rdata    (mem_rdata),
        .O_wen          (wen),
        .O_rd_addr      (wr_rd),
        .O_wr_data      (wr_data),
        .O_fwd_valid    (fwd_valid),
        .O_fwd_rd       (fwd_rd),
        .O_fwd_data     (fwd_data),
        .O_load_pending (load_pending),
        .O_load_rd      (load_rd),
        .O_commit       (commit),
        .O_commit_pc    (commit_pc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference load: pick bytes out of the doubleword memory image
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int unsigned off,
                                             input logic [2:0] fmt);
        logic [7:0]  mem [8];
        int unsigned size;
        logic [63:0] v;
        for (int i = 0; i < 8; i++) mem[i] = rdata[8*i +: 8];
        case (fmt)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010, 3'b110: size = 4;
            default:        size = 8;
        endcase
        v = '0;
        for (int k = 0; k < int'(size); k++)
            if (off + k < 8) v = v | (64'(mem[off + k]) << (8 * k));
        if (fmt[2] == 1'b0 && size < 8 && v[8*size-1])
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic idle_inputs;
        valid      = 1'b0;
        rd_addr    = '0;
        rd_wen     = 1'b0;
        result     = '0;
        is_load    = 1'b0;
        load_fmt   = '0;
        pc         = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_commit"}, commit, 1'b0);
        check({tag, "_wen"}, wen, 1'b0);
        check({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input bit w,
                               input logic [63:0] data, input logic [63:0] ipc);
        check({tag, "_commit"}, commit, 1'b1);
        check({tag, "_wen"}, wen, 64'(w && rd != 0));
        check({tag, "_fwd_valid"}, fwd_valid, 64'(w && rd != 0));
        check({tag, "_rd"}, wr_rd, rd);
        check({tag, "_fwd_rd"}, fwd_rd, rd);
        check({tag, "_data"}, wr_data, data);
        check({tag, "_fwd_data"}, fwd_data, data);
        check({tag, "_pc"}, commit_pc, ipc);
        check({tag, "_pending"}, load_pending, 1'b0);
    endtask

    task automatic drive_op(input string tag, input logic [4:0] rd, input bit w, input bit ld,
                            input logic [2:0] fmt, input logic [63:0] res, input logic [63:0] ipc);
        check({tag, "_ready_at_issue"}, ready, 1'b1);
        valid    = 1'b1;
        rd_addr  = rd;
        rd_wen   = w;
        is_load  = ld;
        load_fmt = fmt;
        result   = res;
        pc       = ipc;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] rd, input bit w,
                           input logic [63:0] res, input logic [63:0] ipc);
        drive_op(tag, rd, w, 1'b0, 3'b000, res, ipc);
        tick;
        valid = 1'b0;
        check_write(tag, rd, w, res, ipc);
    endtask

    // Load with rvalid 'delay' cycles after acceptance; optional junk valids while waiting
    task automatic run_load(input string tag, input logic [4:0] rd, input bit w,
                            input logic [63:0] addr, input logic [2:0] fmt, input int delay,
                            input logic [63:0] rdata, input logic [63:0] ipc, input bit junk);
        drive_op(tag, rd, w, 1'b1, fmt, addr, ipc);
        tick;
        valid = 1'b0;
        for (int d = 0; d < delay; d++) begin
            check({tag, "_wait_pending"}, load_pending, 1'b1);
            check({tag, "_wait_ready"}, ready, 1'b0);
            check({tag, "_wait_load_rd"}, load_rd, rd);
            check({tag, "_wait_commit"}, commit, 1'b0);
            if (junk) begin
                valid   = 1'b1;
                rd_addr = 5'($urandom);
                rd_wen  = 1'b1;
                is_load = 1'($urandom);
                result  = {$urandom, $urandom};
                pc      = {$urandom, $urandom};
            end
            if (d == delay - 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            tick;
        end
        valid      = 1'b0;
        mem_rvalid = 1'b0;
        check_write(tag, rd, w, ref_load(rdata, int'(addr[2:0]), fmt), ipc);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset values
        tick;
        tick;
        check("rst_wen", wen, 1'b0);
        check("rst_commit", commit, 1'b0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_pending", load_pending, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_rd", wr_rd, 0);
        check("rst_data", wr_data, 0);
        check("rst_fwd_data", fwd_data, 0);
        check("rst_pc", commit_pc, 0);
        check("rst_load_rd", load_rd, 0);
        rst = 1'b0;

        // Single ADD and the following quiet cycle
        run_alu("add", 5'd5, 1'b1, 64'h1234, 64'h8000_0000);
        check("add_const_data", wr_data, 64'h1234);
        tick;
        check_quiet("add_after");
        check("add_after_ready", ready, 1'b1);

        // Back-to-back non-loads, then a write to x0
        for (int i = 1; i <= 3; i++) begin
            drive_op("b2b", 5'(i), 1'b1, 1'b0, 3'b000, 64'h100 + 64'(i), 64'h8000_0100 + 64'(4*i));
            tick;
            check_write("b2b", 5'(i), 1'b1, 64'h100 + 64'(i), 64'h8000_0100 + 64'(4*i));
        end
        run_alu("rd0", 5'd0, 1'b1, 64'hDEAD, 64'h8000_0200);
        tick;
        check_quiet("rd0_after");

        // Directed loads with known results
        run_load("lb", 5'd10, 1'b1, 64'h1003, 3'b000, 4, 64'h0000_0000_8000_0000, 64'h8000_0300, 1'b0);
        check("lb_const", wr_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lbu", 5'd11, 1'b1, 64'h1003, 3'b100, 2, 64'h0000_0000_8000_0000, 64'h8000_0304, 1'b0);
        check("lbu_const", wr_data, 64'h80);
        run_load("lwu", 5'd12, 1'b1, 64'h2004, 3'b110, 1, 64'h8765_4321_0000_0000, 64'h8000_0308, 1'b0);
        check("lwu_const", wr_data, 64'h8765_4321);
        run_load("lw", 5'd13, 1'b1, 64'h2004, 3'b010, 3, 64'h8765_4321_0000_0000, 64'h8000_030C, 1'b1);
        check("lw_const", wr_data, 64'hFFFF_FFFF_8765_4321);

        // Stray response while idle
        tick;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        mem_rvalid = 1'b0;
        check_quiet("stray");
        check("stray_pending", load_pending, 1'b0);
        check("stray_ready", ready, 1'b1);
        tick;
        check_quiet("stray_after");

        // Reset while waiting for load data, then a late response
        drive_op("rst_mid", 5'd9, 1'b1, 1'b1, 3'b011, 64'h3000, 64'h8000_0400);
        tick;
        valid = 1'b0;
        tick;
        check("rst_mid_pending_before", load_pending, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_pending", load_pending, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_load_rd", load_rd, 0);
        check("rst_mid_pc", commit_pc, 0);
        tick;
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111_2222_3333_4444;
        tick;
        mem_rvalid = 1'b0;
        check_quiet("rst_mid_late");
        check("rst_mid_late_pending", load_pending, 1'b0);
        check("rst_mid_late_ready", ready, 1'b1);
        check("rst_mid_late_data", wr_data, 0);

        // Load accepted during the WRITE of the previous instruction
        run_alu("pre", 5'd7, 1'b1, 64'h77, 64'h8000_0500);
        run_load("ld_in_write", 5'd8, 1'b1, 64'h0, 3'b011, 2, 64'hCAFE_F00D_1234_5678, 64'h8000_0504, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid = 1'($urandom);
                    mem_rdata  = {$urandom, $urandom};
                    tick;
                    mem_rvalid = 1'b0;
                    check_quiet("rnd_gap");
                    check("rnd_gap_ready", ready, 1'b1);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                run_load("rnd_ld", 5'($urandom), 1'($urandom), {$urandom, $urandom}, 3'($urandom),
                         int'($urandom_range(1, 4)), {$urandom, $urandom}, {$urandom, $urandom},
                         1'($urandom));
            end else begin
                run_alu("rnd_alu", 5'($urandom), 1'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom});
            end
        end

        valid = 1'b0;
        tick;
        check_quiet("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_wbu.md
# ysyx_040750_wbu

Write-back unit of the full-pipeline core. Sits directly upstream of the GPR file and owns its single write port (write enable, destination address, write data). It accepts retiring instructions from the execute/LSU stage over a valid/ready handshake and waits for load data from the data-memory response channel. It then aligns and sign/zero-extends load data. It drives one GPR write per retired instruction, plus forwarding, load-hazard and commit signals.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- I_sys_clk  in  1  core clock; all state updates on the rising edge.
- I_rst  in  1  reset; asynchronous, active-high.
- I_valid  in  1  upstream instruction valid.
- O_ready  out  1  WBU can accept an instruction this cycle.
- I_rd_addr  in  5  destination register.
- I_rd_wen  in  1  instruction writes rd.
- I_result  in  XLEN  ALU result for non-loads; byte address for loads.
- I_is_load  in  1  instruction is a load.
- I_load_fmt  in  3  funct3 of the load: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 treated as LD.
- I_pc  in  XLEN  PC of the instruction.
- I_mem_rvalid  in  1  load response valid, one-cycle pulse.
- I_mem_rdata  in  XLEN  8-byte-aligned doubleword containing the load data.
- O_wen, O_rd_addr[4:0], O_wr_data[XLEN]  out  GPR write port.
- O_fwd_valid, O_fwd_rd[4:0], O_fwd_data[XLEN]  out  bypass of the value being written this cycle.
- O_load_pending  out  1  a load is waiting for data.
- O_load_rd  out  5  rd of the pending load.
- O_commit  out  1  instruction retires this cycle.
- O_commit_pc  out  XLEN  PC of the retiring instruction.

## Operation
- States:
  - IDLE: no instruction held.
  - WAIT_LOAD: load accepted, waiting for data.
  - WRITE: result held, written this cycle.
- O_ready = 1 in IDLE and WRITE; 0 in WAIT_LOAD. It is combinational from state only and does not depend on I_valid.
- Accept = I_valid & O_ready. On accept, latch rd, rd_wen, pc. Then:
  - Non-load: latch I_result and go to WRITE.
  - Load: latch fmt and offset I_result[2:0], then go to WAIT_LOAD.
- WAIT_LOAD with I_mem_rvalid: extract and extend the data, go to WRITE. I_valid is ignored here because O_ready = 0.
- Load extraction: shifted = I_mem_rdata >> (8 × offset), with zero fill. Then take the low 8/16/32/64 bits and sign- or zero-extend per fmt.
  - Misaligned accesses are not trapped; they produce exactly this shifted value.
- WRITE:
  - O_wen = rd_wen & (rd ≠ 0).
  - O_fwd_valid = O_wen.
  - O_commit = 1.
  - Next state: the state implied by an accept in the same cycle, otherwise IDLE.
- I_mem_rvalid outside WAIT_LOAD is ignored, with no state change.
- Outputs are driven from state registers only.
  - O_rd_addr, O_wr_data, O_fwd_rd, O_fwd_data and O_commit_pc are valid only while in WRITE; they hold their last value otherwise.
  - O_load_pending = (state == WAIT_LOAD). O_load_rd = latched rd.
- Reset, at any time including mid-load:
  - State goes to IDLE and all registers clear to 0; the pending load is discarded.
  - A later stray I_mem_rvalid is ignored.
  - Outputs during and after reset: O_wen, O_fwd_valid, O_commit and O_load_pending are 0; all data/address outputs are 0; O_ready = 1.

## Timing
- Non-load accepted in cycle N → O_wen/O_commit in cycle N+1; the GPR is updated at the end of N+1.
- Load accepted in N, I_mem_rvalid in M (M ≥ N+1) → write in M+1.
- Back-to-back non-loads: throughput of 1 per cycle, with no bubble.
- A load following a non-load: accepted while in WRITE.
- The forwarding outputs are required because the GPR read is combinational: a reader in the WRITE cycle sees the old GPR value.
- Decode must stall when O_load_pending is set and O_load_rd matches one of its sources.

## Structure
- Shared header/package ysyx_040750_defs holds:
  - The load-format codes (LB…LWU).
  - The WBU state encoding: 2-bit, IDLE=0, WAIT_LOAD=1, WRITE=2.
  - XLEN.
- One combinational sub-module, ysyx_040750_load_ext (rdata, offset, fmt → extended data). It is instantiated once and unit-testable on its own.

## Test plan
- Reset then ADD result 0x1234 to rd=5, accepted cycle 1 → cycle 2: O_wen=1, O_rd_addr=5, O_wr_data=0x1234, O_commit=1, O_fwd_valid=1. Cycle 3: all strobes 0.
- Three back-to-back non-loads (rd=1,2,3) → three consecutive write cycles with O_ready held at 1; a non-load to rd=0 gives O_commit=1 with O_wen=0.
- LB at offset 3, rvalid 4 cycles later, rdata=0x00000000_80000000 → O_wr_data=0xFFFFFFFF_FFFFFF80. O_load_pending=1 and O_ready=0 throughout the wait.
- The same data with LBU → 0x80. LWU offset 4 on rdata=0x87654321_00000000 → 0x87654321. LW → 0xFFFFFFFF_87654321.
- Stray I_mem_rvalid in IDLE → no write, no state change.
- Assert I_rst during WAIT_LOAD, then deliver rvalid → no write, O_load_pending=0, O_ready=1.
- Load accepted in the same cycle as the WRITE of a previous instruction → the previous write occurs and WAIT_LOAD is entered the next cycle.
